// File: rtl/cellrv32_npu_addr_sequencer.sv
// ---------------------------------------------------------------------------
// cellrv32_npu_addr_sequencer
//
// Drives one NPU load counter (a DSP adder whose loaded value appears three
// cycles after the load strobe) so that it streams a run of consecutive
// addresses. It accepts one (start address, length) command at a time and
// emits the addresses with back-pressure.
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high. A producer holds valid and its payload stable until the
// transfer. Here cmd_ready_o depends only on state. addr_valid_o and addr_o
// never depend on addr_ready_i.
//
// Ports
//   clk_i, rstn_i     clock and asynchronous active-low reset
//   cmd_valid_i       command valid
//   cmd_ready_o       command ready (only in IDLE)
//   cmd_addr_i        first address of the run
//   cmd_len_i         number of addresses to emit (0 is legal)
//   flush_i           synchronous abort of the current run
//   cnt_enable_o      counter enable
//   cnt_load_o        counter load strobe
//   cnt_start_o       counter start value (latched command address)
//   cnt_val_i         counter current value
//   addr_valid_o      addr_o valid
//   addr_ready_i      consumer accepts addr_o
//   addr_o            current address (counter value while running)
//   last_o            final beat of the command
//   busy_o            sequencer not idle
//   done_o            one-cycle pulse when a command completes or is flushed
//   state_o           debug view of the FSM state encoding
// ---------------------------------------------------------------------------
module cellrv32_npu_addr_sequencer #(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [LEN_WIDTH-1:0]  cmd_len_i,
  input  logic                  flush_i,
  output logic                  cnt_enable_o,
  output logic                  cnt_load_o,
  output logic [ADDR_WIDTH-1:0] cnt_start_o,
  input  logic [ADDR_WIDTH-1:0] cnt_val_i,
  output logic                  addr_valid_o,
  input  logic                  addr_ready_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  last_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [2:0]            state_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_WARM = 3'd2,
    S_RUN  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] start_q, start_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic [1:0]            warm_q, warm_d;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= S_IDLE;
      start_q     <= '0;
      remaining_q <= '0;
      warm_q      <= '0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      remaining_q <= remaining_d;
      warm_q      <= warm_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    start_d      = start_q;
    remaining_d  = remaining_q;
    warm_d       = warm_q;
    cmd_ready_o  = 1'b0;
    cnt_enable_o = 1'b0;
    cnt_load_o   = 1'b0;
    addr_valid_o = 1'b0;
    addr_o       = '0;
    last_o       = 1'b0;
    done_o       = 1'b0;

    case (state_q)
      S_IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          start_d     = cmd_addr_i;
          remaining_d = cmd_len_i;
          warm_d      = '0;
          state_d     = (cmd_len_i == '0) ? S_DONE : S_LOAD;
        end
      end

      S_LOAD: begin
        // The load path cannot stall: enable stays high regardless of the consumer.
        cnt_load_o   = 1'b1;
        cnt_enable_o = 1'b1;
        warm_d       = '0;
        state_d      = flush_i ? S_DONE : S_WARM;
      end

      S_WARM: begin
        // Two cycles here put the loaded value on cnt_val_i right as RUN starts.
        cnt_enable_o = 1'b1;
        warm_d       = warm_q + 2'd1;
        if (warm_q == 2'd1) state_d = S_RUN;
        if (flush_i)        state_d = S_DONE;
      end

      S_RUN: begin
        addr_valid_o = 1'b1;
        addr_o       = cnt_val_i;
        last_o       = (remaining_q == LEN_WIDTH'(1));
        // Stalling freezes the counter so addr_o stays stable.
        cnt_enable_o = addr_ready_i;
        if (addr_ready_i) begin
          remaining_d = remaining_q - LEN_WIDTH'(1);
          if (remaining_q == LEN_WIDTH'(1)) state_d = S_DONE;
        end
        if (flush_i) state_d = S_DONE;
      end

      S_DONE: begin
        done_o  = 1'b1;
        warm_d  = '0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign cnt_start_o = start_q;
  assign busy_o      = (state_q != S_IDLE);
  assign state_o     = state_q;

endmodule

// File: tb/tb_cellrv32_npu_addr_sequencer.sv
module tb_cellrv32_npu_addr_sequencer;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic [15:0] cmd_len = '0;
  logic        flush = 1'b0;
  logic        cnt_enable, cnt_load;
  logic [31:0] cnt_start;
  logic [31:0] cnt_val;
  logic        addr_valid;
  logic        addr_ready = 1'b0;
  logic [31:0] addr;
  logic        last, busy, done;
  logic [2:0]  state;

  cellrv32_npu_addr_sequencer #(.ADDR_WIDTH(32), .LEN_WIDTH(16)) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_addr_i   (cmd_addr),
    .cmd_len_i    (cmd_len),
    .flush_i      (flush),
    .cnt_enable_o (cnt_enable),
    .cnt_load_o   (cnt_load),
    .cnt_start_o  (cnt_start),
    .cnt_val_i    (cnt_val),
    .addr_valid_o (addr_valid),
    .addr_ready_i (addr_ready),
    .addr_o       (addr),
    .last_o       (last),
    .busy_o       (busy),
    .done_o       (done),
    .state_o      (state)
  );

  // ---------------- counter model: loaded value visible 3 cycles after load ----------------
  logic        s1_v, s2_v;
  logic [31:0] s1_d, s2_d;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_v <= 1'b0; s2_v <= 1'b0; s1_d <= '0; s2_d <= '0; cnt_val <= '0;
    end else begin
      s1_v <= cnt_load & cnt_enable;
      s1_d <= cnt_start;
      s2_v <= s1_v;
      s2_d <= s1_d;
      if (s2_v)            cnt_val <= s2_d;
      else if (cnt_enable) cnt_val <= cnt_val + 32'd1;
    end
  end

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q[$];   // {last, addr}
  int n_checks = 0;
  int n_errors = 0;
  int beats = 0;
  logic        hold_v = 1'b0;
  logic [31:0] hold_a = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_run(input logic [31:0] a, input int l);
    for (int i = 0; i < l; i++) begin
      logic [31:0] ea;
      ea = a + 32'(i);
      exp_q.push_back({(i == l - 1), ea});
    end
  endtask

  // monitor: sample on the falling edge
  always @(negedge clk) begin
    if (rstn) begin
      if (hold_v && addr_valid) check("stall_hold", addr, hold_a);
      hold_v = addr_valid && !addr_ready;
      hold_a = addr;
      if (addr_valid && addr_ready) begin
        beats++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_beat: addr 0x%0h last %0b with nothing expected", addr, last);
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          check("beat", {last, addr}, e);
        end
      end
    end else begin
      hold_v = 1'b0;
    end
  end

  // ---------------- driver ----------------
  // Issues one command, optionally stalls the consumer for sl cycles before
  // beat index sb, and checks first-valid and done offsets from the accept cycle.
  task automatic run_cmd(input logic [31:0] a, input logic [15:0] l, input int sb, input int sl,
                         input int exp_first, input int exp_done);
    int acc, first, done_cyc, left;
    bit done_seen;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = l;
    addr_ready = 1'b1; flush = 1'b0; beats = 0;
    push_run(a, int'(l));
    @(negedge clk);
    check("cmd_ready_idle", cmd_ready, 1'b1);
    acc = cyc; first = -1; done_cyc = -1; done_seen = 0; left = sl;
    for (int k = 0; k < 200 && !done_seen; k++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      if (cyc >= acc + 4 && beats == sb && left > 0) begin
        addr_ready = 1'b0;
        left--;
      end else begin
        addr_ready = 1'b1;
      end
      @(negedge clk);
      if (addr_valid && first < 0) first = cyc - acc;
      if (done) begin
        done_seen = 1;
        done_cyc  = cyc - acc;
        check("done_cmd_ready", cmd_ready, 1'b0);
        check("done_addr_valid", addr_valid, 1'b0);
      end
    end
    check("done_seen", done_seen, 1'b1);
    check("first_valid_offset", first, exp_first);
    check("done_offset", done_cyc, exp_done);
    check("beat_count", beats, l);
    check("queue_empty", exp_q.size(), 0);
    @(negedge clk);
    check("done_pulse_1cyc", done, 1'b0);
    check("busy_after", busy, 1'b0);
    check("ready_after", cmd_ready, 1'b1);
    exp_q.delete();
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [31:0] addr;
    logic [15:0] len;
    int          sb;
    int          sl;
    int          exp_first;
    int          exp_done;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int fl_cyc, done_cyc, ra, rl, rsb, rsl;
    bit fl_done, done_seen;

    vecs[0] = '{32'h0000_0100, 16'd4, -1, 0, 4, 8};
    vecs[1] = '{32'h0000_0000, 16'd0, -1, 0, -1, 1};
    vecs[2] = '{32'h0000_0040, 16'd3, 1, 2, 4, 9};
    vecs[3] = '{32'hFFFF_FFFE, 16'd4, -1, 0, 4, 8};
    vecs[4] = '{32'h0000_1234, 16'd7, 3, 1, 4, 12};

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_addr_valid", addr_valid, 1'b0);
    check("rst_cnt_enable", cnt_enable, 1'b0);
    check("rst_cnt_load", cnt_load, 1'b0);
    check("rst_cnt_start", cnt_start, 32'h0);
    check("rst_last", last, 1'b0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // table-driven commands
    for (int i = 0; i < 5; i++)
      run_cmd(vecs[i].addr, vecs[i].len, vecs[i].sb, vecs[i].sl, vecs[i].exp_first, vecs[i].exp_done);

    // random commands
    for (int i = 0; i < 4; i++) begin
      ra  = int'($urandom);
      rl  = int'($urandom_range(1, 6));
      rsb = int'($urandom_range(0, rl - 1));
      rsl = int'($urandom_range(0, 3));
      run_cmd(32'(ra), 16'(rl), rsb, rsl, 4, 4 + rl + rsl);
    end

    // flush after 3 beats of a 10-beat run
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_addr = 32'h500; cmd_len = 16'd10;
    addr_ready = 1'b1; beats = 0;
    push_run(32'h500, 10);
    @(negedge clk);
    check("flush_accept", cmd_ready, 1'b1);
    fl_done = 0; fl_cyc = -100; done_cyc = -1; done_seen = 0;
    for (int k = 0; k < 100 && !done_seen; k++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      if (beats == 3 && !fl_done) begin
        flush = 1'b1; addr_ready = 1'b0; fl_done = 1; fl_cyc = cyc;
      end else begin
        flush = 1'b0; addr_ready = 1'b1;
      end
      @(negedge clk);
      if (done) begin
        done_seen = 1; done_cyc = cyc;
        check("flush_done_no_valid", addr_valid, 1'b0);
      end
    end
    flush = 1'b0;
    check("flush_done_seen", done_seen, 1'b1);
    check("flush_done_next_cycle", done_cyc - fl_cyc, 1);
    check("flush_beats", beats, 3);
    @(negedge clk);
    check("flush_busy_drop", busy, 1'b0);
    exp_q.delete();
    run_cmd(32'h0000_0600, 16'd2, -1, 0, 4, 6);

    // cmd_valid in RUN ignored, then async reset mid-run
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_addr = 32'h300; cmd_len = 16'd8;
    addr_ready = 1'b1; beats = 0;
    push_run(32'h300, 8);
    @(negedge clk);
    check("rr_accept", cmd_ready, 1'b1);
    for (int k = 0; k < 50 && beats < 2; k++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(negedge clk);
    end
    check("rr_two_beats", beats, 2);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_addr = 32'h999; cmd_len = 16'd5;
    @(negedge clk);
    check("run_cmd_ready", cmd_ready, 1'b0);
    check("run_busy", busy, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    check("run_still_valid", addr_valid, 1'b1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rstn = 1'b0;
    #1;
    check("async_busy", busy, 1'b0);
    check("async_addr_valid", addr_valid, 1'b0);
    check("async_cmd_ready", cmd_ready, 1'b1);
    check("async_cnt_enable", cnt_enable, 1'b0);
    check("async_cnt_start", cnt_start, 32'h0);
    @(negedge clk);
    exp_q.delete();
    @(posedge clk); #1;
    rstn = 1'b1;
    run_cmd(32'h0000_0200, 16'd2, -1, 0, 4, 6);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
